sweep_controller: RTL
=====================

SWEEP_CONTROLLER -- requirements
Module: sweep_controller

Interface
REQ-001 Parameter: MAX_FREQ, default 25000, highest legal frequency word in Hz (Nyquist for a 50 kHz sample rate).
REQ-002 Port: clk  input  1  single clock; all logic is on its rising edge.
REQ-003 Port: rst_n  input  1  reset; synchronous, active-low.
REQ-004 Port: start  input  1  request to begin a sweep; sampled only in IDLE.
REQ-005 Port: abort  input  1  terminates any sweep; takes priority over start.
REQ-006 Port: continuous  input  1  1 = restart from f_start after f_stop; latched at start.
REQ-007 Port: f_start  input  32  first frequency in Hz; latched at start.
REQ-008 Port: f_stop  input  32  last frequency in Hz; latched at start.
REQ-009 Port: f_step  input  32  unsigned step magnitude in Hz; latched at start.
REQ-010 Port: dwell  input  32  clk cycles per frequency point (0 treated as 1); latched at start.
REQ-011 Port: freq_out  output  32  frequency word for the waveform generator's freq input.
REQ-012 Port: en_out  output  1  channel enable for the waveform generator.
REQ-013 Port: busy  output  1  high while a sweep is running.
REQ-014 Port: step_strobe  output  1  one-cycle pulse in the first cycle each new freq_out value is presented.
REQ-015 Port: done  output  1  one-cycle pulse on normal (non-aborted) completion.
REQ-016 Port: err  output  1  one-cycle pulse when a start is rejected.

Function
REQ-017 States: IDLE and SWEEP; busy = en_out = (state == SWEEP).
REQ-018 Start validity: reject when f_start > MAX_FREQ, f_stop > MAX_FREQ, or (f_step == 0 and f_start != f_stop).
REQ-019 Rejected start: err pulses on the next cycle; state remains IDLE; freq_out is unchanged.
REQ-020 Valid start in IDLE: next cycle enters SWEEP with freq_out = f_start, step_strobe = 1, and all config latched.
REQ-021 Config input changes during SWEEP have no effect.
REQ-022 Direction: up when latched f_stop >= f_start, otherwise down.
REQ-023 Each freq_out value is held for exactly max(dwell,1) cycles, counted by a 32-bit down-counter.
REQ-024 At dwell expiry, when freq_out != f_stop: up uses next = min(freq_out + f_step, f_stop), computed at 33 bits so it cannot wrap; down uses next = max(freq_out - f_step, f_stop), with no underflow; step_strobe pulses.
REQ-025 At dwell expiry with freq_out == f_stop and continuous = 1: freq_out = f_start and step_strobe pulses; the sweep continues indefinitely.
REQ-026 At dwell expiry with freq_out == f_stop and continuous = 0: next cycle goes to IDLE with done = 1, en_out = 0, and freq_out holding f_stop.
REQ-027 f_start == f_stop is a single point: dwell once, then done (or repeat the point if continuous).
REQ-028 Abort (any state): next cycle enters IDLE with en_out = 0 and busy = 0; done, err and step_strobe stay 0; freq_out holds its last value.
REQ-029 Simultaneous start and abort in IDLE: abort wins; no sweep starts and no err is raised.
REQ-030 start during SWEEP is ignored (no restart, no err).
REQ-031 step_strobe, done and err are mutually exclusive, and each lasts one cycle.

Reset
REQ-032 While rst_n = 0 at a clk edge: state = IDLE; freq_out = 0; en_out = busy = step_strobe = done = err = 0; dwell counter = 0; latched config = 0.
REQ-033 Reset mid-sweep takes effect at that edge, with no done pulse; after rst_n rises, the next start is accepted normally.

Verification
REQ-034 Up sweep: f_start=1000, f_stop=1300, f_step=100, dwell=3, continuous=0 -> freq_out 1000,1100,1200,1300, each held 3 cycles; 4 step_strobes; done 1 cycle after the last 1300 cycle; 12 busy cycles.
REQ-035 Clamped down sweep: f_start=500, f_stop=120, f_step=200, dwell=0 -> freq_out 500,300,120, one cycle each; done follows; never below 120.
REQ-036 Continuous wrap: 100->300, step 100, dwell=2, continuous=1 -> 100,100,200,200,300,300,100,...; no done; abort -> en_out=0 next cycle, no done.
REQ-037 Errors: f_stop=30000 -> err pulse, busy stays 0; f_step=0 with 100->200 -> err; f_step=0 with 100->100 -> accepted, single point, done.
REQ-038 Overflow and priority: f_start=0, f_stop=25000, f_step=32'hFFFF_FFF0 -> second point is 25000, then done; start and abort together in IDLE -> nothing happens; rst_n low mid-sweep -> all outputs 0 on the next edge.

Source files
------------

// File: rtl/sweep_controller.sv
// Frequency sweep sequencer: steps a waveform generator's frequency word from
// f_start to f_stop in f_step increments, holding each point for a dwell time.
module sweep_controller #(
    parameter int unsigned MAX_FREQ = 25000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        abort,
    input  logic        continuous,
    input  logic [31:0] f_start,
    input  logic [31:0] f_stop,
    input  logic [31:0] f_step,
    input  logic [31:0] dwell,
    output logic [31:0] freq_out,
    output logic        en_out,
    output logic        busy,
    output logic        step_strobe,
    output logic        done,
    output logic        err
);

    localparam int unsigned W = 32;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t       state;
    logic [W-1:0] cfg_start;
    logic [W-1:0] cfg_stop;
    logic [W-1:0] cfg_step;
    logic [W-1:0] cfg_reload;
    logic [W-1:0] cnt;
    logic         cfg_cont;
    logic         cfg_up;

    logic         start_ok_c;
    logic [W-1:0] dwell_m1_c;
    logic [W:0]   up_sum_c;
    logic [W-1:0] next_up_c;
    logic [W-1:0] down_gap_c;
    logic [W-1:0] next_down_c;

    // Start validity and the dwell reload value (dwell of 0 behaves as 1).
    assign start_ok_c = (f_start <= W'(MAX_FREQ)) && (f_stop <= W'(MAX_FREQ))
                        && !((f_step == '0) && (f_start != f_stop));
    assign dwell_m1_c = (dwell == '0) ? '0 : dwell - W'(1);

    // Next point, clamped at f_stop; the up path is one bit wider so a huge step cannot wrap.
    assign up_sum_c    = {1'b0, freq_out} + {1'b0, cfg_step};
    assign next_up_c   = (up_sum_c > {1'b0, cfg_stop}) ? cfg_stop : up_sum_c[W-1:0];
    assign down_gap_c  = freq_out - cfg_stop;
    assign next_down_c = (down_gap_c <= cfg_step) ? cfg_stop : freq_out - cfg_step;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            freq_out    <= '0;
            en_out      <= 1'b0;
            busy        <= 1'b0;
            step_strobe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            cnt         <= '0;
            cfg_start   <= '0;
            cfg_stop    <= '0;
            cfg_step    <= '0;
            cfg_reload  <= '0;
            cfg_cont    <= 1'b0;
            cfg_up      <= 1'b0;
        end else begin
            step_strobe <= 1'b0;
            done        <= 1'b0;
            err         <= 1'b0;
            case (state)
                IDLE: begin
                    if (abort) begin
                        state <= IDLE;
                    end else if (start) begin
                        if (start_ok_c) begin
                            state       <= SWEEP;
                            busy        <= 1'b1;
                            en_out      <= 1'b1;
                            freq_out    <= f_start;
                            step_strobe <= 1'b1;
                            cnt         <= dwell_m1_c;
                            cfg_start   <= f_start;
                            cfg_stop    <= f_stop;
                            cfg_step    <= f_step;
                            cfg_reload  <= dwell_m1_c;
                            cfg_cont    <= continuous;
                            cfg_up      <= (f_stop >= f_start);
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                SWEEP: begin
                    if (abort) begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        en_out <= 1'b0;
                    end else if (cnt != '0) begin
                        cnt <= cnt - W'(1);
                    end else if (freq_out != cfg_stop) begin
                        freq_out    <= cfg_up ? next_up_c : next_down_c;
                        step_strobe <= 1'b1;
                        cnt         <= cfg_reload;
                    end else if (cfg_cont) begin
                        freq_out    <= cfg_start;
                        step_strobe <= 1'b1;
                        cnt         <= cfg_reload;
                    end else begin
                        state  <= IDLE;
                        busy   <= 1'b0;
                        en_out <= 1'b0;
                        done   <= 1'b1;
                    end
                end
            endcase
        end
    end

endmodule
